fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch front end of the 32-bit MIPS pipeline, sitting directly upstream of the IF/ID register. It owns the fetch PC and drives a single-outstanding request/acknowledge port to instruction memory. Fetched words go into a small instruction queue, together with their PC+4. The queue hands entries to IF/ID with a valid/ready handshake, and a taken branch redirects fetch and squashes everything in flight.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- DEPTH, 2, instruction queue entries; power of two, ≥2.

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- redirect  in  1  taken branch (PCSrc); flush and refetch from redirect_pc
- redirect_pc  in  32  branch target
- imem_req  out  1  fetch request, held until imem_ack
- imem_addr  out  32  fetch address, stable while imem_req=1 and no ack
- imem_ack  in  1  response valid; imem_rdata sampled this cycle, completes request
- imem_rdata  in  32  fetched instruction
- out_valid  out  1  queue head valid
- out_ready  in  1  IF/ID accepts head
- out_instruction  out  32  head instruction; 32'h0 (nop) when empty
- out_pc_next  out  32  head PC+4; 32'h0 when empty

## Operation
- Registers:
  - fetch_pc, the next address to fetch
  - kill_addr, the address of an abandoned request
  - queue storage, with head, tail and count (0..DEPTH)
  - FSM state
- Each queue entry holds {instruction, fetch_pc+4}.
- FSM states:
  - IDLE: imem_req=0, imem_addr=fetch_pc. Go to REQ if redirect or count_next<DEPTH; else stay.
  - REQ: imem_req=1, imem_addr=fetch_pc.
    - ack & !redirect: push {rdata, fetch_pc+4}; fetch_pc+=4. Go to REQ if count_next<DEPTH, else IDLE.
    - ack & redirect: drop rdata, fetch_pc<=redirect_pc, stay in REQ.
    - !ack & redirect: kill_addr<=fetch_pc, fetch_pc<=redirect_pc, go to KILL.
  - KILL: imem_req=1, imem_addr=kill_addr. The request is held until its ack so the handshake is honoured.
    - On ack: drop rdata, go to REQ.
    - A further redirect updates fetch_pc and stays in KILL unless ack is also high.
- Pop: out_valid & out_ready; the head advances.
- count_next = count + push − pop.
- Redirect is dominant:
  - the queue is cleared (count, head, tail ← 0)
  - a same-cycle pop is ignored (IF/ID is being flushed anyway)
  - a same-cycle push is suppressed
- A request is issued only while count<DEPTH, and only one is ever outstanding, so a push never overflows.
- Full with a simultaneous pop: count_next=DEPTH−1, so IDLE moves to REQ next cycle.
- Arithmetic:
  - fetch_pc+4 wraps modulo 2^32 (32'hFFFF_FFFC → 32'h0000_0000)
  - redirect_pc is taken as-is; bits [1:0] are not checked

## Timing
- Reset values:
  - state=IDLE, fetch_pc=RESET_PC, count=0
  - imem_req=0, imem_addr=RESET_PC
  - out_valid=0, out_instruction=0, out_pc_next=0
- The first imem_req rises the first clock edge after reset deassertion.
- Reset asserted mid-request drops imem_req immediately (asynchronous); the pending response is not tracked.
- Latency: an ack in cycle N makes the entry visible on out_* in cycle N+1.
- Zero-wait memory (ack in the same cycle as req) sustains one fetch per cycle: imem_req stays high and imem_addr increments by 4 each cycle.
- Redirect in cycle N:
  - out_valid=0 in cycle N+1
  - request for redirect_pc in cycle N+1, or on the cycle after the killed request's ack
- out_* are driven from registered queue state only; there is no combinational path from imem_rdata to outputs.

## Test plan
- Reset, zero-wait memory (imem_rdata=addr), out_ready=1:
  - imem_addr = 0, 4, 8… on consecutive cycles
  - out_instruction=0,4,8… with out_pc_next=4,8,12…
  - first out_valid two cycles after reset release
- out_ready=0, DEPTH=2:
  - exactly two acks accepted, then imem_req=0 and count=2
  - out_ready pulsed for one cycle → imem_req=1 the next cycle at addr 8
- Memory with 3-cycle ack latency; redirect=1, redirect_pc=32'h100 in the second wait cycle:
  - imem_addr stays at the old address until its ack
  - that data is not queued
  - next request at 32'h100
  - first out_instruction is from 32'h100, with out_pc_next=32'h104
- Queue holding 2 entries, redirect together with out_ready=1 and a same-cycle ack:
  - next cycle out_valid=0, count=0
  - fetch_pc=redirect_pc
- Set RESET_PC=32'hFFFF_FFF8:
  - addresses FFFF_FFF8, FFFF_FFFC, 0000_0000
  - out_pc_next of the second entry = 32'h0
- Assert reset while in KILL and while the queue is full:
  - all outputs return to their reset values immediately
  - fetch restarts at RESET_PC

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, drives a single-outstanding
// imem request/ack port and buffers fetched words with their PC+4 for IF/ID.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc_next
);

  localparam int             AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_KILL = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   kill_addr_q, kill_addr_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   ins_q [DEPTH];
  logic [31:0]   ins_d [DEPTH];
  logic [31:0]   pcn_q [DEPTH];
  logic [31:0]   pcn_d [DEPTH];
  logic          push_s;
  logic          pop_s;

  // Port decode from registered state only.
  always_comb begin
    imem_req        = (state_q != ST_IDLE);
    imem_addr       = (state_q == ST_KILL) ? kill_addr_q : fetch_pc_q;
    out_valid       = (count_q != {CW{1'b0}});
    out_instruction = out_valid ? ins_q[head_q] : 32'h0000_0000;
    out_pc_next     = out_valid ? pcn_q[head_q] : 32'h0000_0000;
  end

  // Queue bookkeeping; a redirect wipes the queue and overrides push and pop.
  always_comb begin
    ins_d   = ins_q;
    pcn_d   = pcn_q;
    push_s  = (state_q == ST_REQ) && imem_ack && !redirect;
    pop_s   = out_valid && out_ready && !redirect;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect) begin
      head_d  = {AW{1'b0}};
      tail_d  = {AW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      count_d = count_q + CW'(push_s) - CW'(pop_s);
      if (push_s) begin
        ins_d[tail_q] = imem_rdata;
        pcn_d[tail_q] = fetch_pc_q + 32'd4;
        tail_d        = tail_q + AW'(1);
      end else begin
        tail_d = tail_q;
      end
      if (pop_s) begin
        head_d = head_q + AW'(1);
      end else begin
        head_d = head_q;
      end
    end
  end

  // Fetch FSM next-state and PC update.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    kill_addr_d = kill_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = ST_REQ;
        end else if (count_d < DEPTH_C) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (imem_ack && redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = ST_REQ;
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = (count_d < DEPTH_C) ? ST_REQ : ST_IDLE;
        end else if (redirect) begin
          // Abandoned request must still see its ack before a new one issues.
          kill_addr_d = fetch_pc_q;
          fetch_pc_d  = redirect_pc;
          state_d     = ST_KILL;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_KILL: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
        if (imem_ack) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_KILL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      fetch_pc_q  <= RESET_PC;
      kill_addr_q <= 32'h0000_0000;
      head_q      <= {AW{1'b0}};
      tail_q      <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        ins_q[i] <= 32'h0000_0000;
        pcn_q[i] <= 32'h0000_0000;
      end
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      kill_addr_q <= kill_addr_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        ins_q[i] <= ins_d[i];
        pcn_q[i] <= pcn_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a configurable-latency
// memory responder; a second instance exercises PC wrap-around.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req, imem_ack, out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] imem_addr, imem_rdata, out_instruction, out_pc_next;

  logic        w_req, w_ack, w_valid;
  logic        w_redirect = 1'b0;
  logic        w_ready = 1'b1;
  logic [31:0] w_addr, w_rdata, w_ins, w_pcn;

  int lat = 1;
  int wcnt;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clock(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_pc_next(out_pc_next)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
    .clock(clk), .reset(reset), .redirect(w_redirect), .redirect_pc(32'h0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack),
    .imem_rdata(w_rdata), .out_valid(w_valid), .out_ready(w_ready),
    .out_instruction(w_ins), .out_pc_next(w_pcn)
  );

  // Memory model: returns the address as data, acking after lat cycles of req.
  assign imem_ack   = imem_req && (wcnt == lat - 1);
  assign imem_rdata = imem_addr;
  assign w_ack      = w_req;
  assign w_rdata    = w_addr;

  always @(posedge clk or posedge reset) begin
    if (reset) wcnt <= 0;
    else if (!imem_req || imem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  typedef struct {
    bit          rst;
    int          lat;
    bit          rd;
    logic [31:0] rpc;
    bit          rdy;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_v;
    logic [31:0] e_ins;
    logic [31:0] e_pcn;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, input int l, input bit rd, input logic [31:0] rpc,
                     input bit rdy, input bit e_req, input logic [31:0] e_addr,
                     input bit e_v, input logic [31:0] e_ins, input logic [31:0] e_pcn);
    vec_t v;
    v.rst = rst; v.lat = l; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v; v.e_ins = e_ins; v.e_pcn = e_pcn;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit e_req, input logic [31:0] e_addr,
                         input bit e_v, input logic [31:0] e_ins, input logic [31:0] e_pcn);
    chk({tag, ".req"},   {31'h0, imem_req},  {31'h0, e_req});
    chk({tag, ".addr"},  imem_addr,          e_addr);
    chk({tag, ".valid"}, {31'h0, out_valid}, {31'h0, e_v});
    chk({tag, ".ins"},   out_instruction,    e_ins);
    chk({tag, ".pcn"},   out_pc_next,        e_pcn);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    redirect = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // Zero-wait streaming with out_ready=1.
    add(1,1,0,0,1, 0,32'h0,  0,32'h0,32'h0);
    add(0,1,0,0,1, 1,32'h0,  0,32'h0,32'h0);
    add(0,1,0,0,1, 1,32'h4,  1,32'h0,32'h4);
    add(0,1,0,0,1, 1,32'h8,  1,32'h4,32'h8);
    add(0,1,0,0,1, 1,32'hC,  1,32'h8,32'hC);
    // Back-pressure: fill to DEPTH, then a one-cycle pop.
    add(1,1,0,0,0, 0,32'h0,  0,32'h0,32'h0);
    add(0,1,0,0,0, 1,32'h0,  0,32'h0,32'h0);
    add(0,1,0,0,0, 1,32'h4,  1,32'h0,32'h4);
    add(0,1,0,0,0, 0,32'h8,  1,32'h0,32'h4);
    add(0,1,0,0,1, 0,32'h8,  1,32'h0,32'h4);
    add(0,1,0,0,0, 1,32'h8,  1,32'h4,32'h8);
    add(0,1,0,0,0, 0,32'hC,  1,32'h4,32'h8);
    // 3-cycle memory; redirect during the second wait cycle of addr 4.
    add(1,3,0,0,1,       0,32'h0,   0,32'h0,32'h0);
    add(0,3,0,0,1,       1,32'h0,   0,32'h0,32'h0);
    add(0,3,0,0,1,       1,32'h0,   0,32'h0,32'h0);
    add(0,3,0,0,1,       1,32'h0,   0,32'h0,32'h0);
    add(0,3,0,0,1,       1,32'h4,   1,32'h0,32'h4);
    add(0,3,1,32'h100,1, 1,32'h4,   0,32'h0,32'h0);
    add(0,3,0,0,1,       1,32'h4,   0,32'h0,32'h0);
    add(0,3,0,0,1,       1,32'h100, 0,32'h0,32'h0);
    add(0,3,0,0,1,       1,32'h100, 0,32'h0,32'h0);
    add(0,3,0,0,1,       1,32'h100, 0,32'h0,32'h0);
    add(0,3,0,0,1,       1,32'h104, 1,32'h100,32'h104);
    // Redirect with a same-cycle ack and pop.
    add(1,1,0,0,1,       0,32'h0,   0,32'h0,32'h0);
    add(0,1,0,0,1,       1,32'h0,   0,32'h0,32'h0);
    add(0,1,1,32'h200,1, 1,32'h4,   1,32'h0,32'h4);
    add(0,1,0,0,1,       1,32'h200, 0,32'h0,32'h0);
    add(0,1,0,0,1,       1,32'h204, 1,32'h200,32'h204);
    // Redirect with a full queue and a same-cycle pop.
    add(1,1,0,0,0,       0,32'h0,   0,32'h0,32'h0);
    add(0,1,0,0,0,       1,32'h0,   0,32'h0,32'h0);
    add(0,1,0,0,0,       1,32'h4,   1,32'h0,32'h4);
    add(0,1,1,32'h300,1, 0,32'h8,   1,32'h0,32'h4);
    add(0,1,0,0,0,       1,32'h300, 0,32'h0,32'h0);
    add(0,1,0,0,0,       1,32'h304, 1,32'h300,32'h304);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) begin
        lat = vecs[i].lat;
        do_reset();
      end else begin
        @(negedge clk);
      end
      redirect    = vecs[i].rd;
      redirect_pc = vecs[i].rpc;
      out_ready   = vecs[i].rdy;
      chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
              vecs[i].e_v, vecs[i].e_ins, vecs[i].e_pcn);
    end

    // PC wrap-around from RESET_PC = FFFF_FFF8.
    redirect  = 1'b0;
    out_ready = 1'b0;
    do_reset();
    chk("wrap0.req",  {31'h0, w_req}, 32'h0);
    chk("wrap0.addr", w_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("wrap1.addr", w_addr, 32'hFFFF_FFF8);
    chk("wrap1.valid", {31'h0, w_valid}, 32'h0);
    @(negedge clk);
    chk("wrap2.addr", w_addr, 32'hFFFF_FFFC);
    chk("wrap2.ins",  w_ins,  32'hFFFF_FFF8);
    chk("wrap2.pcn",  w_pcn,  32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap3.addr", w_addr, 32'h0000_0000);
    chk("wrap3.ins",  w_ins,  32'hFFFF_FFFC);
    chk("wrap3.pcn",  w_pcn,  32'h0000_0000);

    // Reset asserted while a killed request is outstanding.
    lat       = 3;
    out_ready = 1'b1;
    do_reset();
    repeat (5) @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'h400;
    @(negedge clk);
    redirect = 1'b0;
    chk_all("kill", 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
    #2 reset = 1'b1;
    #1 chk_all("kill_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_all("kill_restart", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

    // Reset asserted with a full queue.
    lat       = 1;
    out_ready = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    chk_all("full", 1'b0, 32'h8, 1'b1, 32'h0, 32'h4);
    #2 reset = 1'b1;
    #1 chk_all("full_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_all("full_restart", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
